// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD miter scheduler.
package gcd_pkg;

    localparam int unsigned W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        RESP
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter
    import gcd_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IW'((32'(ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Shares one gcd_dest_m miter between NREQ requesters: accept, start, watch, respond.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned W    = W_DEF,
    parameter  int unsigned TMO  = 100,
    localparam int unsigned IW   = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              core_start,
    output logic [W-1:0]      core_ain,
    output logic [W-1:0]      core_bin,
    input  logic [W-1:0]      core_ao1,
    input  logic [W-1:0]      core_bo1,
    input  logic [W-1:0]      core_ao2,
    input  logic [W-1:0]      core_bo2,
    input  logic              core_equiv,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [W-1:0]      rsp_gcd,
    output logic              rsp_mismatch,
    output logic              rsp_timeout,
    output logic [7:0]        fail_cnt
);

    state_t          r_state;
    state_t          w_state_nx;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_id;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [7:0]      r_cyc_cnt;
    logic            r_mis;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_gid;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_accept;
    logic            w_done;
    logic            w_tmo;
    logic            w_rsp_hs;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_gid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_a   = req_a[i*W +: W];
                w_b   = req_b[i*W +: W];
                w_gid = IW'(i);
            end
        end
    end

    assign core_ain = r_a;
    assign core_bin = r_b;

    // req_ready is gated by reset so it reads 0 while reset is held, even with requests pending.
    always_comb begin
        w_state_nx = r_state;
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        w_accept   = 1'b0;
        w_rsp_hs   = 1'b0;
        w_done     = (core_bo1 == '0) && (core_bo2 == '0);
        w_tmo      = (r_cyc_cnt == 8'(TMO - 1));
        case (r_state)
            IDLE: begin
                if (reset) req_ready = w_grant;
                w_accept = |req_ready;
                if (w_accept) w_state_nx = START;
            end
            START: begin
                core_start = 1'b1;
                w_state_nx = RUN;
            end
            RUN: begin
                if (w_done || w_tmo) w_state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_hs   = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_cyc_cnt    <= '0;
            r_mis        <= 1'b0;
            rsp_id       <= '0;
            rsp_gcd      <= '0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b0;
            fail_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_a  <= w_a;
                r_b  <= w_b;
                r_id <= w_gid;
            end
            if (r_state == START) begin
                r_cyc_cnt <= '0;
                r_mis     <= 1'b0;
            end
            if (r_state == RUN) begin
                r_cyc_cnt <= r_cyc_cnt + 8'd1;
                if (!core_equiv) r_mis <= 1'b1;
                // Completion wins over the watchdog when both land in the same cycle.
                if (w_done) begin
                    rsp_id       <= r_id;
                    rsp_gcd      <= core_ao1;
                    rsp_mismatch <= r_mis | (core_ao1 != core_ao2) | ~core_equiv;
                    rsp_timeout  <= 1'b0;
                end else if (w_tmo) begin
                    rsp_id       <= r_id;
                    rsp_gcd      <= core_ao1;
                    rsp_mismatch <= r_mis;
                    rsp_timeout  <= 1'b1;
                end
            end
            if (w_rsp_hs) begin
                if (r_id == IW'(NREQ - 1)) r_rr_ptr <= '0;
                else                       r_rr_ptr <= r_id + 1'b1;
                if ((rsp_mismatch || rsp_timeout) && (fail_cnt != 8'hFF))
                    fail_cnt <= fail_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_sched.sv
// Bench for gcd_sched: behavioural miter model, table-driven jobs, scoreboard of expected responses.
module tb_gcd_sched;

    localparam int NREQ = 4;
    localparam int W    = 6;
    localparam int TMO  = 100;
    localparam int MD_NORM   = 0;
    localparam int MD_STUCK  = 1;
    localparam int MD_GLITCH = 2;

    typedef struct {
        int id;
        int a;
        int b;
        int mode;
        int gcd;
        int mis;
        int tmo;
    } vec_t;

    typedef struct {
        int id;
        int gcd;
        int mis;
        int tmo;
        int lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              core_start;
    logic [W-1:0]      core_ain;
    logic [W-1:0]      core_bin;
    logic [W-1:0]      m_a1, m_b1, m_a2, m_b2;
    logic              core_equiv;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_gcd;
    logic              rsp_mismatch;
    logic              rsp_timeout;
    logic [7:0]        fail_cnt;

    int   checks = 0;
    int   errors = 0;
    int   mode   = MD_NORM;
    int   cyc    = 0;
    int   m_steps;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_sched #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .core_start   (core_start),
        .core_ain     (core_ain),
        .core_bin     (core_bin),
        .core_ao1     (m_a1),
        .core_bo1     (m_b1),
        .core_ao2     (m_a2),
        .core_bo2     (m_b2),
        .core_equiv   (core_equiv),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_gcd      (rsp_gcd),
        .rsp_mismatch (rsp_mismatch),
        .rsp_timeout  (rsp_timeout),
        .fail_cnt     (fail_cnt)
    );

    // Miter model: two Euclid copies; STUCK freezes both, GLITCH drops equiv on the 2nd RUN cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_a1 <= '0; m_b1 <= '0; m_a2 <= '0; m_b2 <= '0;
            m_steps <= 0;
        end else if (core_start) begin
            m_a1 <= core_ain; m_b1 <= core_bin;
            m_a2 <= core_ain; m_b2 <= core_bin;
            m_steps <= 0;
        end else begin
            m_steps <= m_steps + 1;
            if (mode != MD_STUCK) begin
                if (m_b1 != '0) begin m_a1 <= m_b1; m_b1 <= m_a1 % m_b1; end
                if (m_b2 != '0) begin m_a2 <= m_b2; m_b2 <= m_a2 % m_b2; end
            end
        end
    end
    assign core_equiv = (m_a1 == m_a2) && (m_b1 == m_b2) && !(mode == MD_GLITCH && m_steps == 1);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_wait(input string nm, input int budget);
        checks++;
        errors++;
        $display("FAIL %s: no event within %0d cycles, expected one", nm, budget);
    endtask

    function automatic int euclid_steps(input int a, input int b);
        int s = 0;
        int t;
        while (b != 0) begin
            t = a % b; a = b; b = t; s++;
        end
        return s;
    endfunction

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.id  = v.id;
        e.gcd = v.gcd;
        e.mis = v.mis;
        e.tmo = v.tmo;
        e.lat = (v.mode == MD_STUCK) ? TMO + 2 : 3 + euclid_steps(v.a, v.b);
        return e;
    endfunction

    // Response monitor: sampled on the falling edge, away from the active edge.
    int   t_acc  = 0;
    int   n_acc  = 0;
    int   n_resp = 0;
    int   exp_fail = 0;
    bit   inflight = 0;
    bit   shown    = 0;
    bit   fc_pend  = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!reset) begin
            inflight = 0; shown = 0; fc_pend = 0; exp_fail = 0;
        end else begin
            if (fc_pend) begin
                chk("fail_cnt", 32'(fail_cnt), exp_fail);
                fc_pend = 0;
            end
            if (inflight && req_valid != '0) chk("ready_busy", 32'(req_ready), 0);
            if ((req_valid & req_ready) != '0) begin
                t_acc = cyc; inflight = 1; n_acc++;
            end
            if (rsp_valid) begin
                if (!shown) begin
                    shown = 1;
                    if (sb.size() == 0) begin
                        cur = '{default: 0};
                        checks++; errors++;
                        $display("FAIL rsp_unexpected: got response id %0d, expected none", rsp_id);
                    end else begin
                        cur = sb[0];
                        chk("rsp_id", 32'(rsp_id), cur.id);
                        chk("rsp_gcd", 32'(rsp_gcd), cur.gcd);
                        chk("rsp_mismatch", 32'(rsp_mismatch), cur.mis);
                        chk("rsp_timeout", 32'(rsp_timeout), cur.tmo);
                        chk("rsp_latency", cyc - t_acc, cur.lat);
                    end
                end else begin
                    chk("hold_id", 32'(rsp_id), cur.id);
                    chk("hold_gcd", 32'(rsp_gcd), cur.gcd);
                    chk("hold_mismatch", 32'(rsp_mismatch), cur.mis);
                    chk("hold_timeout", 32'(rsp_timeout), cur.tmo);
                end
                if (rsp_ready) begin
                    if (sb.size() > 0) sb.delete(0);
                    if ((cur.mis != 0 || cur.tmo != 0) && exp_fail < 255) exp_fail++;
                    shown = 0; inflight = 0; fc_pend = 1; n_resp++;
                end
            end
        end
    end

    task automatic wait_acc(input int target);
        for (int k = 0; k < 200 && n_acc < target; k++) begin
            @(posedge clk); #1;
        end
        if (n_acc < target) fail_wait("accept_wait", 200);
    endtask

    task automatic wait_resp(input int target);
        for (int k = 0; k < 400 && n_resp < target; k++) begin
            @(posedge clk); #1;
        end
        if (n_resp < target) fail_wait("resp_wait", 400);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_core_start", 32'(core_start), 0);
        chk("rst_core_ain", 32'(core_ain), 0);
        chk("rst_core_bin", 32'(core_bin), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_gcd", 32'(rsp_gcd), 0);
        chk("rst_rsp_mismatch", 32'(rsp_mismatch), 0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
        chk("rst_fail_cnt", 32'(fail_cnt), 0);
    endtask

    task automatic set_ops(input int id, input int a, input int b);
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
    endtask

    task automatic run_vec(input vec_t v);
        int na;
        int nr;
        na = n_acc;
        nr = n_resp;
        mode = v.mode;
        sb.push_back(mk_exp(v));
        set_ops(v.id, v.a, v.b);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        #1;
        chk("grant_onehot", 32'(req_ready), 1 << v.id);
        wait_acc(na + 1);
        req_valid = '0;
        wait_resp(nr + 1);
    endtask

    vec_t vt[7];
    vec_t rr[4];

    initial begin
        int nr;
        int c_rel;
        vt[0] = '{0, 42,  0, MD_NORM,  42, 0, 0};
        vt[1] = '{2, 12, 18, MD_NORM,   6, 0, 0};
        vt[2] = '{1,  0,  0, MD_NORM,   0, 0, 0};
        vt[3] = '{3, 63, 27, MD_NORM,   9, 0, 0};
        vt[4] = '{1, 30, 20, MD_STUCK, 30, 0, 1};
        vt[5] = '{0, 21, 34, MD_NORM,   1, 0, 0};
        vt[6] = '{2, 48, 36, MD_NORM,  12, 0, 0};
        rr[0] = '{0,  9,  6, MD_NORM, 3, 0, 0};
        rr[1] = '{1, 20,  8, MD_NORM, 4, 0, 0};
        rr[2] = '{2, 35, 14, MD_NORM, 7, 0, 0};
        rr[3] = '{3, 13,  5, MD_NORM, 1, 0, 0};

        reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) run_vec(vt[i]);

        // Glitched equivalence with a stalled consumer: fields must hold for 5 cycles.
        mode = MD_GLITCH;
        sb.push_back(mk_exp('{2, 12, 18, MD_GLITCH, 6, 1, 0}));
        nr = n_resp;
        rsp_ready = 1'b0;
        set_ops(2, 12, 18);
        req_valid = 4'b0100;
        wait_acc(n_acc + 1);
        req_valid = '0;
        for (int k = 0; k < 50 && !rsp_valid; k++) begin
            @(posedge clk); #1;
        end
        if (!rsp_valid) fail_wait("glitch_rsp", 50);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        wait_resp(nr + 1);

        // Fresh reset, then all four requesters valid: service order 0,1,2,3,0.
        reset = 1'b0;
        #1;
        sb.delete();
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mode = MD_NORM;
        foreach (rr[i]) set_ops(rr[i].id, rr[i].a, rr[i].b);
        for (int i = 0; i < 5; i++) sb.push_back(mk_exp(rr[i % 4]));
        nr = n_resp;
        req_valid = '1;
        wait_resp(nr + 5);
        req_valid = '0;
        chk("rr_sb_empty", sb.size(), 0);

        // Reset in the middle of a long job: no response, outputs clear at once.
        mode = MD_STUCK;
        set_ops(3, 30, 20);
        req_valid = 4'b1000;
        wait_acc(n_acc + 1);
        req_valid = '0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        c_rel = cyc;
        mode = MD_NORM;
        nr = n_resp;
        sb.push_back(mk_exp('{1, 20, 8, MD_NORM, 4, 0, 0}));
        set_ops(1, 20, 8);
        req_valid = 4'b0010;
        #1;
        chk("first_grant", 32'(req_ready), 2);
        wait_acc(n_acc + 1);
        req_valid = '0;
        chk("first_accept_cycle", t_acc, c_rel);
        wait_resp(nr + 1);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_sched.md
# gcd_sched

Round-robin scheduler that shares one `gcd_dest_m` equivalence miter between `NREQ` requesters. It accepts operand pairs over valid/ready, launches the miter with a one-cycle `start`, and monitors both GCD copies until they terminate or a watchdog expires. It returns the result, the requester ID and the equivalence/timeout status over a valid/ready response port. It sits between the stimulus generators and the miter in the equivalence-checking harness.

## Interface
- `NREQ`, 4, number of requesters, 2..8
- `W`, 6, operand width, matching the miter
- `TMO`, 100, watchdog limit in RUN cycles, must be < 2^8
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request present, one bit per requester
- `req_ready`  out  NREQ  one-hot accept
- `req_a`, `req_b`  in  NREQ*W  operands, requester i at bits [i*W +: W]
- `core_start`  out  1  miter start
- `core_ain`, `core_bin`  out  W  miter operands
- `core_ao1`, `core_bo1`, `core_ao2`, `core_bo2`  in  W  miter register outputs
- `core_equiv`  in  1  miter equivalence flag
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accept
- `rsp_id`  out  clog2(NREQ)  requester served
- `rsp_gcd`  out  W  `core_ao1` value at completion
- `rsp_mismatch`  out  1  the two copies diverged
- `rsp_timeout`  out  1  watchdog expired
- `fail_cnt`  out  8  saturating count of responses with mismatch or timeout

## Operation
- FSM states: IDLE, START, RUN, RESP.
- **IDLE**
  - `req_ready` is asserted combinationally for the first valid requester at or after `rr_ptr`, searching cyclically.
  - On that handshake: latch operands and ID, go to START.
  - No valid requests: stay in IDLE.
- **START**
  - Assert `core_start` with latched operands for exactly one cycle.
  - Clear `cyc_cnt`, clear the sticky `mis` flag, go to RUN.
- **RUN**
  - `core_start`=0 while `core_ain`/`core_bin` hold the latched operands.
  - Each cycle: `cyc_cnt`++.
  - If `core_equiv`==0, set `mis`.
  - Done when `core_bo1`==0 && `core_bo2`==0:
    - `rsp_gcd` ← `core_ao1`
    - `rsp_mismatch` ← `mis` | (`core_ao1`≠`core_ao2`) | ~`core_equiv`
    - go to RESP.
  - Otherwise, if `cyc_cnt`==TMO-1: `rsp_timeout` ← 1, `rsp_mismatch` ← `mis`, `rsp_gcd` ← `core_ao1`, go to RESP.
  - Done takes priority over timeout in the same cycle.
- **RESP**
  - Hold `rsp_valid`=1 with stable fields until `rsp_ready`.
  - On handshake:
    - `rr_ptr` ← served ID + 1 (mod NREQ)
    - `fail_cnt` increments when mismatch|timeout, saturating at 255
    - go to IDLE.
- Operand edge cases:
  - B=0: done on the first RUN cycle, `rsp_gcd`=A.
  - A=B=0: `rsp_gcd`=0, no error.
- A requester dropping `req_valid` before it is granted is legal; the unit never accepts without a handshake.

## Timing
- Reset values: `req_ready`=0, `core_start`=0, `core_ain`=`core_bin`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_gcd`=0, `rsp_mismatch`=0, `rsp_timeout`=0, `fail_cnt`=0, `rr_ptr`=0, state IDLE.
- Accept in cycle t → `core_start` high in t+1 → first RUN sample in t+2 → `rsp_valid` at t+3 minimum.
- Maximum accept-to-`rsp_valid` latency is TMO+2 cycles.
- Response handshake in cycle r → IDLE in r+1; the next accept is possible in r+1.
- Only one job is in flight at a time; `req_ready` is 0 in every non-IDLE state.
- Reset asserted mid-job aborts it with no response and returns all outputs to reset values immediately.
- After reset release, the first grant goes to the lowest-indexed valid requester.

## Structure
- Shared package `gcd_pkg`: state enum (IDLE/START/RUN/RESP), default W=6, and the `clog2` helper function.
- One sub-module, `rr_arbiter`: parameter NREQ; inputs `req`[NREQ] and `ptr`; output one-hot `grant`; purely combinational.
- The FSM, watchdog, response registers and `fail_cnt` live in `gcd_sched`.

## Test plan
- Requester 0 sends A=42, B=0 → `rsp_valid` at t+3, `rsp_id`=0, `rsp_gcd`=42, mismatch=0, timeout=0.
- Requester 2 sends A=12, B=18 with a correct miter model → `rsp_gcd`=6, mismatch=0, `fail_cnt` stays 0.
- All four requesters valid continuously, `rsp_ready`=1 → served in order 0,1,2,3,0; no requester is granted twice before the others.
- Miter model never clears `bo1`, TMO=100 → `rsp_timeout`=1 exactly 102 cycles after accept, `fail_cnt`=1.
- Miter model pulses `core_equiv`=0 for one mid-run cycle, final `ao1`=`ao2` → `rsp_mismatch`=1; `rsp_ready` held low 5 cycles keeps all fields stable.
- Reset asserted during RUN → outputs return to reset values, no response; after release, requester 1 alone valid is accepted in the first IDLE cycle.
